// File: rtl/noc_request_axi.sv
// noc_request_axi: converts AXI4 AR and AW/W bursts into OpenPiton NC load/store NoC packets, one per 8-byte beat.
module noc_request_axi #(
  parameter int          AXI_ADDR_WIDTH = 40,
  parameter int          AXI_DATA_WIDTH = 64,
  parameter int          AXI_LEN_WIDTH  = 8,
  parameter int          NOC_DATA_WIDTH = 64,
  parameter logic [13:0] SRC_CHIPID     = '0,
  parameter logic [7:0]  SRC_X          = '0,
  parameter logic [7:0]  SRC_Y          = '0,
  parameter logic [13:0] DST_CHIPID     = '0,
  parameter logic [7:0]  DST_X          = '0,
  parameter logic [7:0]  DST_Y          = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  input  logic [AXI_LEN_WIDTH-1:0]  m_axi_arlen,
  input  logic                      m_axi_arvalid,
  output logic                      m_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  input  logic [AXI_LEN_WIDTH-1:0]  m_axi_awlen,
  input  logic                      m_axi_awvalid,
  output logic                      m_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_wdata,
  input  logic                      m_axi_wlast,
  input  logic                      m_axi_wvalid,
  output logic                      m_axi_wready,
  output logic                      noc_valid_out,
  output logic [NOC_DATA_WIDTH-1:0] noc_data_out,
  input  logic                      noc_ready_in,
  output logic [5:0]                transaction_type_wr_data,
  output logic                      transaction_type_wr,
  input  logic                      type_fifo_full
);
  typedef enum logic [2:0] {IDLE, RD_H0, RD_H1, RD_H2, WR_H0, WR_H1, WR_H2, WR_DATA} state_t;
  state_t state, state_nx;
  logic [AXI_ADDR_WIDTH-1:0] addr, addr_nx;
  logic [AXI_LEN_WIDTH-1:0] len, len_nx, beat, beat_nx;
  logic [7:0] mshrid;
  logic prio_rd, prio_rd_nx;
  logic grant_rd, grant_wr, fire, is_rd, is_h0, is_h1, is_h2, last_beat;
  logic [63:0] flit0, flit1, flit2, wdata_rev;
  assign grant_rd = state == IDLE && m_axi_arvalid && (!m_axi_awvalid || prio_rd);
  assign grant_wr = state == IDLE && m_axi_awvalid && !grant_rd;
  assign is_rd = state == RD_H0 || state == RD_H1 || state == RD_H2;
  assign is_h0 = state == RD_H0 || state == WR_H0;
  assign is_h1 = state == RD_H1 || state == WR_H1;
  assign is_h2 = state == RD_H2 || state == WR_H2;
  assign last_beat = beat == len;
  assign m_axi_arready = grant_rd;
  assign m_axi_awready = grant_wr;
  assign m_axi_wready = state == WR_DATA && noc_ready_in;
  // Flit 0 is held back while the response-side FIFO cannot take its descriptor.
  assign noc_valid_out = state == RD_H0 ? !type_fifo_full :
                         state == WR_H0 ? m_axi_wvalid && !type_fifo_full :
                         state == WR_DATA ? m_axi_wvalid : state != IDLE;
  assign fire = noc_valid_out && noc_ready_in;
  assign flit0 = {DST_CHIPID, DST_X, DST_Y, 4'd0, is_rd ? 8'd2 : 8'd3, is_rd ? 8'd14 : 8'd15, mshrid, 6'd0};
  assign flit1 = {{(48-AXI_ADDR_WIDTH){1'b0}}, addr, 3'b011, 13'd0};
  assign flit2 = {SRC_CHIPID, SRC_X, SRC_Y, 34'd0};
  assign wdata_rev = {<<8{m_axi_wdata}};
  assign noc_data_out = is_h0 ? flit0 : is_h1 ? flit1 : is_h2 ? flit2 : state == WR_DATA ? wdata_rev : '0;
  assign transaction_type_wr = is_h0 && fire;
  assign transaction_type_wr_data = is_h0 ? {is_rd ? 1'b0 : m_axi_wlast, is_rd && last_beat, 1'b0, addr[3],
                                             is_rd ? 2'd1 : 2'd2} : 6'd0;
  always_comb begin
    state_nx = state;
    addr_nx = addr;
    len_nx = len;
    beat_nx = beat;
    prio_rd_nx = prio_rd;
    case (state)
      IDLE: begin
        if (grant_rd) begin
          state_nx = RD_H0;
          addr_nx = m_axi_araddr;
          len_nx = m_axi_arlen;
          beat_nx = '0;
          prio_rd_nx = 1'b0;
        end else if (grant_wr) begin
          state_nx = WR_H0;
          addr_nx = m_axi_awaddr;
          len_nx = m_axi_awlen;
          beat_nx = '0;
          prio_rd_nx = 1'b1;
        end
      end
      RD_H0: state_nx = fire ? RD_H1 : state;
      RD_H1: state_nx = fire ? RD_H2 : state;
      RD_H2: if (fire) begin
        state_nx = last_beat ? IDLE : RD_H0;
        beat_nx = last_beat ? beat : beat + 1'b1;
        addr_nx = last_beat ? addr : addr + AXI_ADDR_WIDTH'(8);
      end
      WR_H0: state_nx = fire ? WR_H1 : state;
      WR_H1: state_nx = fire ? WR_H2 : state;
      WR_H2: state_nx = fire ? WR_DATA : state;
      WR_DATA: if (fire) begin
        state_nx = m_axi_wlast ? IDLE : WR_H0;
        addr_nx = m_axi_wlast ? addr : addr + AXI_ADDR_WIDTH'(8);
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      beat <= '0;
      mshrid <= '0;
      prio_rd <= 1'b1;
    end else begin
      state <= state_nx;
      addr <= addr_nx;
      len <= len_nx;
      beat <= beat_nx;
      prio_rd <= prio_rd_nx;
      if (transaction_type_wr) mshrid <= mshrid + 8'd1;
    end
  end
endmodule
